// File: rtl/scan_cell_sync_pkg.sv
// Shared constants for the synchronous scan chain.
// Defines the default IO width and synchroniser depth of a scan cell, and
// the bit positions of the two independently latched IO groups
// (io[0] and io[7:1]).
package scan_pkg;

  localparam int NUM_IOS_DEF     = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // io[0] is latched by its own enable, io[7:1] by the other one
  localparam int IO0      = 0;
  localparam int IO7_1_LO = 1;
  localparam int IO7_1_HI = 7;

endpackage

// File: rtl/scan_cell_sync_edge_detect.sv
// Synchroniser plus edge detector for a single scan-interface input.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   async_in    raw input coming from the previous cell / controller
//   sync        input after SYNC_STAGES flops
//   delayed     sync delayed by one more flop (the forwarded copy)
//   rise, fall  single-cycle pulses when sync differs from delayed
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync,
  output logic delayed,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Synchroniser chain followed by the history flop. The history flop
  // doubles as the forwarded output, so every cell adds exactly
  // SYNC_STAGES+1 cycles of delay to each scan signal.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      delayed <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      delayed <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~delayed;
  assign fall = ~sync & delayed;

endmodule

// File: rtl/scan_cell_sync.sv
// One element of the scan chain, running entirely on the system clock.
// The scan interface is oversampled; the shift register captures on the
// synced scan_clk rise, the serial output updates one cycle after the
// synced fall so it only moves while the forwarded clock is low.
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   scan_*_in                    scan signals from the previous cell
//   scan_*_out                   the same signals forwarded, SYNC_STAGES+1 late
//   scan_data_out                serial data to the next cell
//   module_data_in               latched inputs to the attached design
//   module_data_out              outputs of the attached design (parallel load)
//   overrun                      sticky flag: scan_clk phase too short
module scan_cell_sync
  import scan_pkg::*;
#(
  parameter int NUM_IOS     = NUM_IOS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_clk_in,
  input  logic               scan_data_in,
  input  logic               scan_select_in,
  input  logic               scan_latch_io0_en_in,
  input  logic               scan_latch_io7_1_en_in,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select_out,
  output logic               scan_latch_io0_en_out,
  output logic               scan_latch_io7_1_en_out,
  output logic [NUM_IOS-1:0] module_data_in,
  input  logic [NUM_IOS-1:0] module_data_out,
  output logic               overrun
);

  // Upper bit of the io[7:1] group, tracking NUM_IOS if it differs from 8
  localparam int IO_HI = IO7_1_HI + NUM_IOS - NUM_IOS_DEF;

  logic clk_sync, clk_delayed, clk_rise, clk_fall;
  logic data_sync, data_delayed, data_rise, data_fall;
  logic sel_sync, sel_delayed, sel_rise, sel_fall;
  logic l0_sync, l0_delayed, l0_rise, l0_fall;
  logic l71_sync, l71_delayed, l71_rise, l71_fall;
  logic unused_edges;

  logic [NUM_IOS-1:0] sr;
  logic               dout;
  logic               rise_d;
  logic               fall_d;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk), .reset(reset), .async_in(scan_clk_in),
    .sync(clk_sync), .delayed(clk_delayed), .rise(clk_rise), .fall(clk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk(clk), .reset(reset), .async_in(scan_data_in),
    .sync(data_sync), .delayed(data_delayed), .rise(data_rise), .fall(data_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sel_sync (
    .clk(clk), .reset(reset), .async_in(scan_select_in),
    .sync(sel_sync), .delayed(sel_delayed), .rise(sel_rise), .fall(sel_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_l0_sync (
    .clk(clk), .reset(reset), .async_in(scan_latch_io0_en_in),
    .sync(l0_sync), .delayed(l0_delayed), .rise(l0_rise), .fall(l0_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_l71_sync (
    .clk(clk), .reset(reset), .async_in(scan_latch_io7_1_en_in),
    .sync(l71_sync), .delayed(l71_delayed), .rise(l71_rise), .fall(l71_fall)
  );

  // Edge outputs this cell has no use for; collected so they stay visible
  assign unused_edges = ^{clk_sync, data_delayed, data_rise, data_fall,
                          sel_rise, sel_fall, l0_sync, l0_fall,
                          l71_sync, l71_fall};

  assign scan_clk_out            = clk_delayed;
  assign scan_select_out         = sel_delayed;
  assign scan_latch_io0_en_out   = l0_delayed;
  assign scan_latch_io7_1_en_out = l71_delayed;
  assign scan_data_out           = dout;

  // Shift/load, serial output, IO latches and overrun detection.
  // The serial output waits one extra cycle after the synced fall so the
  // next cell never sees data and its clock edge move in the same cycle.
  // Latches read the pre-shift value when they coincide with a shift,
  // which the non-blocking update gives naturally.
  // Overrun fires when a synced rise and fall land on adjacent cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr             <= '0;
      dout           <= 1'b0;
      rise_d         <= 1'b0;
      fall_d         <= 1'b0;
      module_data_in <= '0;
      overrun        <= 1'b0;
    end else begin
      rise_d <= clk_rise;
      fall_d <= clk_fall;

      if (clk_rise) begin
        if (sel_sync) begin
          sr <= module_data_out;
        end else begin
          sr <= {sr[NUM_IOS-2:0], data_sync};
        end
      end

      if (fall_d) begin
        dout <= sr[NUM_IOS-1];
      end

      if (l0_rise) begin
        module_data_in[IO0] <= sr[IO0];
      end

      if (l71_rise) begin
        module_data_in[IO_HI:IO7_1_LO] <= sr[IO_HI:IO7_1_LO];
      end

      if ((clk_rise && fall_d) || (clk_fall && rise_d)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_cell_sync.sv
// Testbench for a two-cell chain of scan_cell_sync. Stimulus tasks update a
// behavioural model of both cells' registers and queue the expected serial
// bits and latched IO bytes; monitors pop and compare whenever the forwarded
// scan clock or latch enables rise.
`timescale 1ns/1ps
module tb_scan_cell_sync;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_clk_in, scan_data_in, scan_select_in, l0_in, l71_in;
  logic [7:0] mdo0, mdo1;

  logic       c0_clk, c0_data, c0_sel, c0_l0, c0_l71, c0_ovr;
  logic [7:0] c0_mdi;
  logic       c1_clk, c1_data, c1_sel, c1_l0, c1_l71, c1_ovr;
  logic [7:0] c1_mdi;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents of the two cells as seen by the scan protocol
  logic [7:0] model_sr0, model_sr1, model_mdi0, model_mdi1;
  logic       q_ser0[$];
  logic       q_ser1[$];
  logic [7:0] q_mdi0[$];
  logic [7:0] q_mdi1[$];

  // Monitor state
  logic [3:0] hist [0:SYNC];
  logic [7:0] cur_mdi0 = 8'd0, cur_mdi1 = 8'd0;
  logic       p_clk0 = 1'b0, p_clk1 = 1'b0;
  logic       p_l00 = 1'b0, p_l710 = 1'b0, p_l01 = 1'b0, p_l711 = 1'b0;
  logic       e_bit;
  logic [7:0] e_byte;

  scan_cell_sync u_cell0 (
    .clk(clk), .reset(reset),
    .scan_clk_in(scan_clk_in), .scan_data_in(scan_data_in),
    .scan_select_in(scan_select_in),
    .scan_latch_io0_en_in(l0_in), .scan_latch_io7_1_en_in(l71_in),
    .scan_clk_out(c0_clk), .scan_data_out(c0_data), .scan_select_out(c0_sel),
    .scan_latch_io0_en_out(c0_l0), .scan_latch_io7_1_en_out(c0_l71),
    .module_data_in(c0_mdi), .module_data_out(mdo0), .overrun(c0_ovr)
  );

  scan_cell_sync u_cell1 (
    .clk(clk), .reset(reset),
    .scan_clk_in(c0_clk), .scan_data_in(c0_data),
    .scan_select_in(c0_sel),
    .scan_latch_io0_en_in(c0_l0), .scan_latch_io7_1_en_in(c0_l71),
    .scan_clk_out(c1_clk), .scan_data_out(c1_data), .scan_select_out(c1_sel),
    .scan_latch_io0_en_out(c1_l0), .scan_latch_io7_1_en_out(c1_l71),
    .module_data_in(c1_mdi), .module_data_out(mdo1), .overrun(c1_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    scan_clk_in = 1'b0; scan_data_in = 1'b0; scan_select_in = 1'b0;
    l0_in = 1'b0; l71_in = 1'b0;
    wait_cycles(2);
    q_ser0.delete(); q_ser1.delete(); q_mdi0.delete(); q_mdi1.delete();
    model_sr0 = 8'd0; model_sr1 = 8'd0; model_mdi0 = 8'd0; model_mdi1 = 8'd0;
    reset = 1'b0;
    wait_cycles(1);
  endtask

  // Queue the IO bytes each cell must present after a latch
  task automatic model_latch(input logic w0, input logic w71);
    if (w0) begin
      model_mdi0[0] = model_sr0[0];
      model_mdi1[0] = model_sr1[0];
    end
    if (w71) begin
      model_mdi0[7:1] = model_sr0[7:1];
      model_mdi1[7:1] = model_sr1[7:1];
    end
    q_mdi0.push_back(model_mdi0);
    q_mdi1.push_back(model_mdi1);
  endtask

  // One scan_clk pulse: low phase with data/select set up, then high phase.
  // Optional latch enables rise together with the clock.
  task automatic applyStimulus(input logic data, input logic sel,
                               input int high_c, input int low_c,
                               input logic w0, input logic w71);
    scan_data_in = data;
    scan_select_in = sel;
    wait_cycles(low_c);
    if (w0 || w71) model_latch(w0, w71);
    // Each cell shows its previous MSB to the next one at this rising edge
    q_ser0.push_back(model_sr0[7]);
    q_ser1.push_back(model_sr1[7]);
    if (sel) begin
      model_sr0 = mdo0;
      model_sr1 = mdo1;
    end else begin
      model_sr1 = {model_sr1[6:0], model_sr0[7]};
      model_sr0 = {model_sr0[6:0], data};
    end
    scan_clk_in = 1'b1;
    if (w0) l0_in = 1'b1;
    if (w71) l71_in = 1'b1;
    wait_cycles(high_c);
    scan_clk_in = 1'b0;
    if (w0) l0_in = 1'b0;
    if (w71) l71_in = 1'b0;
  endtask

  task automatic latch_pulse(input logic w0, input logic w71);
    if (w0) l0_in = 1'b1;
    if (w71) l71_in = 1'b1;
    model_latch(w0, w71);
    wait_cycles(2);
    l0_in = 1'b0;
    l71_in = 1'b0;
    wait_cycles(2);
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], 1'b0, 2, 2, 1'b0, 1'b0);
  endtask

  task automatic drain_queues();
    for (int i = 0; i < 300 && (q_ser0.size() + q_ser1.size() + q_mdi0.size() + q_mdi1.size()) != 0; i++)
      wait_cycles(1);
    checkOutput("drain", 8'(q_ser0.size() + q_ser1.size() + q_mdi0.size() + q_mdi1.size()), 8'd0);
  endtask

  // Input history for the fixed forwarding delay of cell 0
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= SYNC; i++) hist[i] = 4'd0;
    end else begin
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {scan_clk_in, scan_select_in, l0_in, l71_in};
    end
  end

  // Scoreboard monitor, sampling on the falling clock edge
  always @(negedge clk) begin
    if (reset) begin
      cur_mdi0 = 8'd0;
      cur_mdi1 = 8'd0;
    end else begin
      checkOutput("fwd0", {4'd0, c0_clk, c0_sel, c0_l0, c0_l71}, {4'd0, hist[SYNC]});

      if (c0_clk && !p_clk0) begin
        if (q_ser0.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL ser0: got forwarded clock rise, expected none at %0t", $time);
        end else begin
          e_bit = q_ser0.pop_front();
          checkOutput("ser0", {7'd0, c0_data}, {7'd0, e_bit});
        end
      end
      if (c1_clk && !p_clk1) begin
        if (q_ser1.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL ser1: got forwarded clock rise, expected none at %0t", $time);
        end else begin
          e_bit = q_ser1.pop_front();
          checkOutput("ser1", {7'd0, c1_data}, {7'd0, e_bit});
        end
      end

      if ((c0_l0 && !p_l00) || (c0_l71 && !p_l710)) begin
        if (q_mdi0.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL mdi0: got latch enable rise, expected none at %0t", $time);
        end else begin
          e_byte = q_mdi0.pop_front();
          cur_mdi0 = e_byte;
        end
      end
      if ((c1_l0 && !p_l01) || (c1_l71 && !p_l711)) begin
        if (q_mdi1.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL mdi1: got latch enable rise, expected none at %0t", $time);
        end else begin
          e_byte = q_mdi1.pop_front();
          cur_mdi1 = e_byte;
        end
      end
      checkOutput("mdi0", c0_mdi, cur_mdi0);
      checkOutput("mdi1", c1_mdi, cur_mdi1);
    end
    p_clk0 = c0_clk; p_clk1 = c1_clk;
    p_l00 = c0_l0; p_l710 = c0_l71; p_l01 = c1_l0; p_l711 = c1_l71;
  end

  initial begin
    int op;
    int r;
    reset = 1'b1;
    scan_clk_in = 1'b0; scan_data_in = 1'b0; scan_select_in = 1'b0;
    l0_in = 1'b0; l71_in = 1'b0;
    mdo0 = 8'd0; mdo1 = 8'd0;
    @(posedge clk); #1;
    reset_dut();

    $display("[TB] reset and idle");
    wait_cycles(10);
    checkOutput("rst_clk_out", {7'd0, c0_clk}, 8'd0);
    checkOutput("rst_data_out", {7'd0, c0_data}, 8'd0);
    checkOutput("rst_sel_out", {7'd0, c0_sel}, 8'd0);
    checkOutput("rst_l0_out", {7'd0, c0_l0}, 8'd0);
    checkOutput("rst_l71_out", {7'd0, c0_l71}, 8'd0);
    checkOutput("rst_mdi", c0_mdi, 8'd0);
    checkOutput("rst_overrun", {7'd0, c0_ovr}, 8'd0);

    $display("[TB] forwarding delay");
    scan_select_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_cycles(1);
      checkOutput("sel_delay", {7'd0, c0_sel}, (i >= SYNC + 1) ? 8'd1 : 8'd0);
    end
    scan_select_in = 1'b0;
    wait_cycles(4);

    $display("[TB] shift 0xA5 and latch");
    shift_byte(8'hA5);
    latch_pulse(1'b1, 1'b0);
    latch_pulse(1'b0, 1'b1);
    wait_cycles(8);
    checkOutput("mdi0_A5", c0_mdi, 8'hA5);

    $display("[TB] two-cell chain");
    shift_byte(8'h3C);
    shift_byte(8'hC3);
    latch_pulse(1'b1, 1'b1);
    wait_cycles(12);
    checkOutput("chain_c0", c0_mdi, 8'hC3);
    checkOutput("chain_c1", c1_mdi, 8'h3C);

    $display("[TB] parallel load");
    mdo0 = 8'h5A;
    mdo1 = 8'($urandom);
    applyStimulus(1'b0, 1'b1, 2, 2, 1'b0, 1'b0);
    shift_byte(8'h00);
    latch_pulse(1'b1, 1'b1);
    wait_cycles(12);
    checkOutput("load_c0", c0_mdi, 8'h00);
    checkOutput("load_c1", c1_mdi, 8'h5A);

    $display("[TB] held latch enable");
    shift_byte(8'hA5);
    l0_in = 1'b1;
    model_latch(1'b1, 1'b0);
    wait_cycles(4);
    applyStimulus(1'b0, 1'b0, 2, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2, 2, 1'b0, 1'b0);
    wait_cycles(8);
    l0_in = 1'b0;
    wait_cycles(10);
    checkOutput("io0_hold", {7'd0, c0_mdi[0]}, 8'd1);

    $display("[TB] latch coinciding with shift");
    applyStimulus(1'b1, 1'b0, 2, 2, 1'b1, 1'b1);
    wait_cycles(10);
    checkOutput("simul", c0_mdi, 8'h94);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        applyStimulus(1'($urandom), 1'b0, $urandom_range(2, 3), $urandom_range(2, 3), 1'b0, 1'b0);
      end else if (op == 6) begin
        mdo0 = 8'($urandom);
        mdo1 = 8'($urandom);
        applyStimulus(1'($urandom), 1'b1, 2, 2, 1'b0, 1'b0);
        scan_select_in = 1'b0;
        wait_cycles(8);
      end else if (op <= 8) begin
        r = $urandom_range(1, 3);
        latch_pulse(r[0], r[1]);
      end else begin
        r = $urandom_range(1, 3);
        applyStimulus(1'($urandom), 1'b0, 2, 2, r[0], r[1]);
      end
    end
    drain_queues();
    checkOutput("no_overrun", {6'd0, c1_ovr, c0_ovr}, 8'd0);

    $display("[TB] overrun");
    reset_dut();
    for (int n = 0; n < 6; n++) applyStimulus(1'b0, 1'b0, 1, 1, 1'b0, 1'b0);
    wait_cycles(10);
    checkOutput("overrun_set", {6'd0, c1_ovr, c0_ovr}, 8'h03);
    wait_cycles(20);
    checkOutput("overrun_sticky", {6'd0, c1_ovr, c0_ovr}, 8'h03);

    $display("[TB] reset mid-shift");
    reset_dut();
    applyStimulus(1'b1, 1'b0, 2, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2, 2, 1'b0, 1'b0);
    wait_cycles(2);
    scan_data_in = 1'b1;
    scan_clk_in = 1'b1;
    wait_cycles(1);
    reset_dut();
    checkOutput("midrst_overrun", {7'd0, c0_ovr}, 8'd0);
    checkOutput("midrst_dout", {7'd0, c0_data}, 8'd0);
    latch_pulse(1'b1, 1'b1);
    wait_cycles(6);
    checkOutput("midrst_sr", c0_mdi, 8'h00);

    $display("[TB] serial output timing");
    for (int n = 0; n < 7; n++) applyStimulus(1'b1, 1'b0, 2, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2, 2, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      wait_cycles(1);
      checkOutput("dout_delay", {7'd0, c0_data}, (i >= SYNC + 2) ? 8'd1 : 8'd0);
    end
    latch_pulse(1'b1, 1'b1);
    drain_queues();
    checkOutput("final_c0", c0_mdi, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
